// File: rtl/rv_defs.sv
// Shared RISC-V definitions: major opcode constants and the ROB entry layout.
package rv_defs;

  // 7-bit major opcodes used to classify instructions held in the ROB.
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } rv_opcode_e;

  // Payload kept per ROB entry. Busy/done flags live in separate vectors
  // so that they can be reset while the payload storage stays a plain RAM.
  typedef struct packed {
    logic        is_store;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        mispredict;
    logic [31:0] target;
  } rob_entry_t;

  // True when the low 7 bits of a {funct3,opcode} field are a store.
  function automatic logic is_store_op(input logic [16:0] opcode);
    return opcode[6:0] == OP_STORE;
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer circular queue.
// Pointers wrap modulo ROB_DEPTH; a flush returns everything to zero.
module rob_ptr_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             issue_in,
  input  logic             commit_in,
  input  logic             flush_in,
  output logic [TAG_W-1:0] head_out,
  output logic [TAG_W-1:0] tail_out,
  output logic [TAG_W:0]   count_out,
  output logic             ready_out,
  output logic             empty_out
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(ROB_DEPTH);

  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   count_q;

  // Pointer and occupancy registers; all hold while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (issue_in)  tail_q <= tail_q + TAG_W'(1);
        if (commit_in) head_q <= head_q + TAG_W'(1);
        unique case ({issue_in, commit_in})
          2'b10:   count_q <= count_q + (TAG_W+1)'(1);
          2'b01:   count_q <= count_q - (TAG_W+1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Occupancy status; ready only below full, so issue never bypasses a commit.
  always_comb begin
    ready_out = (count_q < DEPTH_C);
    empty_out = (count_q == '0);
  end

  assign head_out  = head_q;
  assign tail_out  = tail_q;
  assign count_out = count_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates entries at issue, collects
// out-of-order writebacks, commits the head entry in order and flushes the
// whole buffer when the head resolves as a mispredicted control transfer.
// Optional feature macro: ROB_OPERAND_QUERY_EN adds two combinational
// operand query ports (q1/q2) with same-cycle writeback bypass.
//
// Handshake: an issue transfers on a rising edge where issue_valid_in and
// issue_ready_out are both high, rdy_in is high and no flush is decided in
// that cycle; issue_tag_out names the entry being allocated. Writeback and
// commit are valid-only (no back-pressure).
module reorder_buffer
  import rv_defs::*;
#(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             issue_valid_in,
  input  logic [16:0]      issue_opcode_in,
  input  logic [4:0]       issue_rd_in,
  input  logic [31:0]      issue_pc_in,
  output logic             issue_ready_out,
  output logic [TAG_W-1:0] issue_tag_out,
  input  logic             wb_valid_in,
  input  logic [TAG_W-1:0] wb_tag_in,
  input  logic [31:0]      wb_value_in,
  input  logic             wb_mispredict_in,
  input  logic [31:0]      wb_target_in,
  output logic             commit_valid_out,
  output logic [TAG_W-1:0] commit_tag_out,
  output logic [4:0]       commit_rd_out,
  output logic [31:0]      commit_value_out,
  output logic             commit_is_store_out,
  output logic             flush_out,
  output logic [31:0]      flush_pc_out,
`ifdef ROB_OPERAND_QUERY_EN
  input  logic [TAG_W-1:0] q1_tag_in,
  output logic             q1_ready_out,
  output logic [31:0]      q1_value_out,
  input  logic [TAG_W-1:0] q2_tag_in,
  output logic             q2_ready_out,
  output logic [31:0]      q2_value_out,
`endif
  output logic             rob_empty_out,
  output logic [TAG_W:0]   rob_count_out
);

  rob_entry_t           entries [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] busy_q;
  logic [ROB_DEPTH-1:0] done_q;

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  rob_entry_t       head_e;
  logic             head_ready;
  logic             wb_hit;
  logic             do_issue;
  logic             do_commit;
  logic             do_flush;

  // The issue PC and funct3 bits are not needed for retirement.
  logic unused_issue_bits;
  assign unused_issue_bits = ^{issue_pc_in, issue_opcode_in[16:7]};

  rob_ptr_ctrl #(
    .ROB_DEPTH (ROB_DEPTH),
    .TAG_W     (TAG_W)
  ) u_ptr (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .issue_in  (do_issue),
    .commit_in (do_commit),
    .flush_in  (do_flush),
    .head_out  (head),
    .tail_out  (tail),
    .count_out (rob_count_out),
    .ready_out (issue_ready_out),
    .empty_out (rob_empty_out)
  );

  assign issue_tag_out = tail;

  // Retirement decision from registered flags only, so a writeback reaches
  // commit no earlier than the following edge.
  always_comb begin
    head_e     = entries[head];
    head_ready = busy_q[head] && done_q[head];
    wb_hit     = wb_valid_in && busy_q[wb_tag_in];
    do_flush   = head_ready && head_e.mispredict;
    do_commit  = head_ready && !head_e.mispredict;
    do_issue   = issue_valid_in && issue_ready_out && !do_flush;
  end

  // Entry payload RAM: issue fills the static fields, writeback the results.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (do_issue) begin
        entries[tail].is_store <= is_store_op(issue_opcode_in);
        entries[tail].rd       <= issue_rd_in;
      end
      if (wb_hit) begin
        entries[wb_tag_in].value      <= wb_value_in;
        entries[wb_tag_in].mispredict <= wb_mispredict_in;
        entries[wb_tag_in].target     <= wb_target_in;
      end
    end
  end

  // Busy/done flags; a flush wipes all in-flight entries.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      done_q <= '0;
    end else if (rdy_in) begin
      if (do_flush) begin
        busy_q <= '0;
        done_q <= '0;
      end else begin
        if (wb_hit) done_q[wb_tag_in] <= 1'b1;
        if (do_issue) begin
          busy_q[tail] <= 1'b1;
          done_q[tail] <= 1'b0;
        end
        if (do_commit) begin
          busy_q[head] <= 1'b0;
          done_q[head] <= 1'b0;
        end
      end
    end
  end

  // Registered commit and flush outputs, one cycle after the decision.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      commit_valid_out    <= 1'b0;
      commit_tag_out      <= '0;
      commit_rd_out       <= '0;
      commit_value_out    <= '0;
      commit_is_store_out <= 1'b0;
      flush_out           <= 1'b0;
      flush_pc_out        <= '0;
    end else if (rdy_in) begin
      commit_valid_out <= do_commit;
      flush_out        <= do_flush;
      if (do_commit) begin
        commit_tag_out      <= head;
        commit_rd_out       <= head_e.rd;
        commit_value_out    <= head_e.value;
        commit_is_store_out <= head_e.is_store;
      end
      if (do_flush) flush_pc_out <= head_e.target;
    end
  end

`ifdef ROB_OPERAND_QUERY_EN
  logic wb_fire;
  assign wb_fire = wb_hit && rdy_in;

  // Operand lookup with bypass of a writeback landing this cycle.
  always_comb begin
    q1_ready_out = done_q[q1_tag_in];
    q1_value_out = entries[q1_tag_in].value;
    q2_ready_out = done_q[q2_tag_in];
    q2_value_out = entries[q2_tag_in].value;
    if (wb_fire && (wb_tag_in == q1_tag_in)) begin
      q1_ready_out = 1'b1;
      q1_value_out = wb_value_in;
    end
    if (wb_fire && (wb_tag_in == q2_tag_in)) begin
      q2_ready_out = 1'b1;
      q2_value_out = wb_value_in;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table for in-order commit of
// out-of-order writebacks, plus hand sequences for reset, full, stall and flush.
module tb_reorder_buffer;

  localparam int QW = 42;  // {is_store, rd, tag, value}
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_ALU = 7'b0110011;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        issue_valid_in;
  logic [16:0] issue_opcode_in;
  logic [4:0]  issue_rd_in;
  logic [31:0] issue_pc_in;
  logic        issue_ready_out;
  logic [3:0]  issue_tag_out;
  logic        wb_valid_in;
  logic [3:0]  wb_tag_in;
  logic [31:0] wb_value_in;
  logic        wb_mispredict_in;
  logic [31:0] wb_target_in;
  logic        commit_valid_out;
  logic [3:0]  commit_tag_out;
  logic [4:0]  commit_rd_out;
  logic [31:0] commit_value_out;
  logic        commit_is_store_out;
  logic        flush_out;
  logic [31:0] flush_pc_out;
  logic        rob_empty_out;
  logic [4:0]  rob_count_out;

  int checks = 0;
  int errors = 0;
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] mon_got;
  logic [QW-1:0] mon_exp;
  logic          rdy_at_edge = 1'b0;

  typedef struct {
    logic        iv;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic        wv;
    logic [3:0]  wtag;
    logic [31:0] wval;
    logic [4:0]  exp_count;
    logic        exp_cv;
    logic [3:0]  exp_tag;
  } vec_t;
  vec_t vecs [10];

  reorder_buffer #(.ROB_DEPTH(16), .TAG_W(4)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .issue_valid_in      (issue_valid_in),
    .issue_opcode_in     (issue_opcode_in),
    .issue_rd_in         (issue_rd_in),
    .issue_pc_in         (issue_pc_in),
    .issue_ready_out     (issue_ready_out),
    .issue_tag_out       (issue_tag_out),
    .wb_valid_in         (wb_valid_in),
    .wb_tag_in           (wb_tag_in),
    .wb_value_in         (wb_value_in),
    .wb_mispredict_in    (wb_mispredict_in),
    .wb_target_in        (wb_target_in),
    .commit_valid_out    (commit_valid_out),
    .commit_tag_out      (commit_tag_out),
    .commit_rd_out       (commit_rd_out),
    .commit_value_out    (commit_value_out),
    .commit_is_store_out (commit_is_store_out),
    .flush_out           (flush_out),
    .flush_pc_out        (flush_pc_out),
    .rob_empty_out       (rob_empty_out),
    .rob_count_out       (rob_count_out)
  );

  // Clock and edge bookkeeping
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) rdy_at_edge = rdy_in;

  // Scoreboard: every fresh commit must match the front of exp_q.
  always @(negedge clk_in) begin
    if (rst_in && rdy_at_edge && commit_valid_out) begin
      mon_got = {commit_is_store_out, commit_rd_out, commit_tag_out, commit_value_out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got 0x%0h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL commit_data: got 0x%0h expected 0x%0h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic set_issue(input logic v, input logic [6:0] op, input logic [4:0] rd);
    issue_valid_in  = v;
    issue_opcode_in = {10'h000, op};
    issue_rd_in     = rd;
    issue_pc_in     = 32'h0000_0100;
  endtask

  task automatic set_wb(input logic v, input logic [3:0] tag, input logic [31:0] val,
                        input logic misp, input logic [31:0] tgt);
    wb_valid_in      = v;
    wb_tag_in        = tag;
    wb_value_in      = val;
    wb_mispredict_in = misp;
    wb_target_in     = tgt;
  endtask

  task automatic clear_inputs();
    set_issue(1'b0, 7'h00, 5'd0);
    set_wb(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rdy_in = 1'b1;
    rst_in = 1'b1;
    clear_inputs();
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);

    // Reset state
    check("rst_count", 32'(rob_count_out), 32'd0);
    check("rst_empty", 32'(rob_empty_out), 32'd1);
    check("rst_ready", 32'(issue_ready_out), 32'd1);
    check("rst_tag", 32'(issue_tag_out), 32'd0);
    check("rst_commit_valid", 32'(commit_valid_out), 32'd0);
    check("rst_flush", 32'(flush_out), 32'd0);
    check("rst_flush_pc", flush_pc_out, 32'd0);
    rst_in = 1'b1;

    // Out-of-order writebacks 2,1,0 retire in order 0,1,2
    vecs[0] = '{1'b1, OPC_LD,  5'd1, 1'b0, 4'd0, 32'h00, 5'd1, 1'b0, 4'd1};
    vecs[1] = '{1'b1, OPC_ST,  5'd2, 1'b0, 4'd0, 32'h00, 5'd2, 1'b0, 4'd2};
    vecs[2] = '{1'b1, OPC_ALU, 5'd3, 1'b0, 4'd0, 32'h00, 5'd3, 1'b0, 4'd3};
    vecs[3] = '{1'b0, OPC_ALU, 5'd0, 1'b1, 4'd2, 32'h22, 5'd3, 1'b0, 4'd3};
    vecs[4] = '{1'b0, OPC_ALU, 5'd0, 1'b1, 4'd1, 32'h11, 5'd3, 1'b0, 4'd3};
    vecs[5] = '{1'b0, OPC_ALU, 5'd0, 1'b1, 4'd0, 32'h00, 5'd3, 1'b0, 4'd3};
    vecs[6] = '{1'b0, OPC_ALU, 5'd0, 1'b0, 4'd0, 32'h00, 5'd2, 1'b1, 4'd3};
    vecs[7] = '{1'b0, OPC_ALU, 5'd0, 1'b0, 4'd0, 32'h00, 5'd1, 1'b1, 4'd3};
    vecs[8] = '{1'b0, OPC_ALU, 5'd0, 1'b0, 4'd0, 32'h00, 5'd0, 1'b1, 4'd3};
    vecs[9] = '{1'b0, OPC_ALU, 5'd0, 1'b0, 4'd0, 32'h00, 5'd0, 1'b0, 4'd3};
    exp_q.push_back({1'b0, 5'd1, 4'd0, 32'h00});
    exp_q.push_back({1'b1, 5'd2, 4'd1, 32'h11});
    exp_q.push_back({1'b0, 5'd3, 4'd2, 32'h22});
    for (int i = 0; i < 10; i++) begin
      set_issue(vecs[i].iv, vecs[i].op, vecs[i].rd);
      set_wb(vecs[i].wv, vecs[i].wtag, vecs[i].wval, 1'b0, 32'h0);
      tick();
      check($sformatf("vec%0d_count", i), 32'(rob_count_out), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_commit_valid", i), 32'(commit_valid_out), 32'(vecs[i].exp_cv));
      check($sformatf("vec%0d_tag", i), 32'(issue_tag_out), 32'(vecs[i].exp_tag));
      check($sformatf("vec%0d_empty", i), 32'(rob_empty_out), 32'(vecs[i].exp_count == 5'd0));
    end
    clear_inputs();

    // Asynchronous reset with five entries in flight and a commit on the output
    for (int i = 0; i < 6; i++) begin
      set_issue(1'b1, OPC_ALU, 5'd9);
      tick();
    end
    clear_inputs();
    check("mid_count6", 32'(rob_count_out), 32'd6);
    set_wb(1'b1, 4'd3, 32'h33, 1'b0, 32'h0);
    exp_q.push_back({1'b0, 5'd9, 4'd3, 32'h33});
    tick();
    clear_inputs();
    tick();
    check("mid_count5", 32'(rob_count_out), 32'd5);
    check("mid_commit_valid", 32'(commit_valid_out), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check("async_rst_count", 32'(rob_count_out), 32'd0);
    check("async_rst_empty", 32'(rob_empty_out), 32'd1);
    check("async_rst_commit_valid", 32'(commit_valid_out), 32'd0);
    check("async_rst_tag", 32'(issue_tag_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Fill all 16 entries; tags run 0..15
    for (int i = 0; i < 16; i++) begin
      set_issue(1'b1, OPC_ALU, 5'd10);
      #1;
      check($sformatf("fill_tag%0d", i), 32'(issue_tag_out), 32'(i));
      tick();
    end
    check("full_count", 32'(rob_count_out), 32'd16);
    check("full_ready", 32'(issue_ready_out), 32'd0);
    check("full_tag_wrap", 32'(issue_tag_out), 32'd0);
    check("full_empty", 32'(rob_empty_out), 32'd0);

    // Issue held at full while head becomes done, then commits
    set_wb(1'b1, 4'd0, 32'h0A, 1'b0, 32'h0);
    exp_q.push_back({1'b0, 5'd10, 4'd0, 32'h0A});
    tick();
    check("full_wb_count", 32'(rob_count_out), 32'd16);
    set_wb(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    tick();
    check("full_commit_count", 32'(rob_count_out), 32'd15);
    check("full_commit_ready", 32'(issue_ready_out), 32'd1);
    check("full_commit_tag", 32'(issue_tag_out), 32'd0);
    check("full_commit_valid", 32'(commit_valid_out), 32'd1);
    tick();
    check("refill_count", 32'(rob_count_out), 32'd16);
    check("refill_ready", 32'(issue_ready_out), 32'd0);
    clear_inputs();

    // Stall: rdy_in low for 3 cycles with a writeback held on the inputs
    rdy_in = 1'b0;
    set_wb(1'b1, 4'd1, 32'h5A5A, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_count", i), 32'(rob_count_out), 32'd16);
      check($sformatf("stall%0d_commit_valid", i), 32'(commit_valid_out), 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    check("resume_count", 32'(rob_count_out), 32'd16);
    clear_inputs();
    exp_q.push_back({1'b0, 5'd10, 4'd1, 32'h5A5A});
    tick();
    check("resume_commit_count", 32'(rob_count_out), 32'd15);
    check("resume_commit_valid", 32'(commit_valid_out), 32'd1);

    // Mispredicted head plus same-cycle issue: flush wins, issue dropped
    set_wb(1'b1, 4'd2, 32'h0, 1'b1, 32'h0000_1000);
    tick();
    clear_inputs();
    check("pre_flush", 32'(flush_out), 32'd0);
    check("pre_flush_count", 32'(rob_count_out), 32'd15);
    set_issue(1'b1, OPC_ALU, 5'd11);
    tick();
    clear_inputs();
    check("flush_pulse", 32'(flush_out), 32'd1);
    check("flush_pc", flush_pc_out, 32'h0000_1000);
    check("flush_count", 32'(rob_count_out), 32'd0);
    check("flush_empty", 32'(rob_empty_out), 32'd1);
    check("flush_tag", 32'(issue_tag_out), 32'd0);
    check("flush_commit_valid", 32'(commit_valid_out), 32'd0);
    tick();
    check("flush_once", 32'(flush_out), 32'd0);
    check("flush_count_hold", 32'(rob_count_out), 32'd0);

    // After flush: writeback to a non-busy tag is ignored
    set_issue(1'b1, OPC_ST, 5'd7);
    set_wb(1'b1, 4'd1, 32'hBAD, 1'b0, 32'h0);
    tick();
    check("post_count1", 32'(rob_count_out), 32'd1);
    check("post_tag1", 32'(issue_tag_out), 32'd1);
    set_issue(1'b1, OPC_ALU, 5'd8);
    set_wb(1'b1, 4'd0, 32'h77, 1'b0, 32'h0);
    exp_q.push_back({1'b1, 5'd7, 4'd0, 32'h77});
    tick();
    clear_inputs();
    check("post_count2", 32'(rob_count_out), 32'd2);
    tick();
    check("post_commit_count", 32'(rob_count_out), 32'd1);
    check("post_commit_valid", 32'(commit_valid_out), 32'd1);
    tick();
    check("ignored_wb_count", 32'(rob_count_out), 32'd1);
    check("ignored_wb_no_commit", 32'(commit_valid_out), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, entry count (power of two, >=4).
REQ-002 SHALL have parameter TAG_W, default 4, equal to log2(ROB_DEPTH).
REQ-003 SHALL have port clk_in, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rdy_in, input, 1, global enable; when low, all state holds.
REQ-006 SHALL have ports issue_valid_in (in, 1), issue_opcode_in (in, 17, {funct3,opcode}), issue_rd_in (in, 5), issue_pc_in (in, 32).
REQ-007 SHALL have ports issue_ready_out (out, 1, not full) and issue_tag_out (out, TAG_W, tag of the entry being allocated).
REQ-008 SHALL have ports wb_valid_in (in, 1), wb_tag_in (in, TAG_W), wb_value_in (in, 32), wb_mispredict_in (in, 1), wb_target_in (in, 32).
REQ-009 SHALL have ports commit_valid_out (out, 1), commit_tag_out (out, TAG_W), commit_rd_out (out, 5), commit_value_out (out, 32), commit_is_store_out (out, 1).
REQ-010 SHALL have ports flush_out (out, 1) and flush_pc_out (out, 32).
REQ-011 SHALL have ports rob_empty_out (out, 1) and rob_count_out (out, TAG_W+1).

Function
REQ-012 SHALL be a circular queue with head/tail pointers of TAG_W bits that wrap modulo ROB_DEPTH, plus a count register.
REQ-013 SHALL set issue_ready_out = (count < ROB_DEPTH) and issue_tag_out = tail, combinationally.
REQ-014 SHALL, on issue_valid_in && issue_ready_out, write the entry at tail with busy=1 and done=0, then advance tail.
REQ-015 SHALL, on wb_valid_in to a busy entry, store the value, mispredict flag and target, and set done=1; a writeback to a non-busy entry SHALL be ignored.
REQ-016 SHALL commit at most one entry per cycle: the head entry, when busy and done, without a mispredict flag.
REQ-017 SHALL drive commit_*_out registered, one cycle after the commit decision; commit_is_store_out = (opcode[6:0] == 7'b0100011).
REQ-018 SHALL, when the head entry is done with its mispredict flag set, pulse flush_out for 1 cycle with flush_pc_out = target, clear all busy bits, and set head=tail=count=0 in that cycle.
REQ-019 SHALL give flush priority over a same-cycle issue, which is dropped; the issuer sees the flush and re-fetches.
REQ-020 SHALL, on simultaneous issue and commit, leave count unchanged; issue is permitted at full only when no commit occurs in that cycle (no full-bypass).
REQ-021 SHALL accept a writeback to the head entry and its commit in the same cycle only on the next edge (minimum one-cycle writeback-to-commit latency).
REQ-022 SHALL assert rob_empty_out = (count == 0).

Reset
REQ-023 SHALL clear head, tail, count and all busy/done bits, and zero commit_valid_out, flush_out, flush_pc_out and commit data, while rst_in is low, independent of clk_in.
REQ-024 SHALL behave as an empty ROB on the first edge after release; entry data RAM need not be cleared.

Configuration
REQ-025 Macro ROB_OPERAND_QUERY_EN SHALL add two query ports: qN_tag_in (TAG_W) and qN_ready_out/qN_value_out (1/32), N=1,2, combinationally returning the done flag and value of the tagged entry, with same-cycle writeback bypass.
REQ-026 Without ROB_OPERAND_QUERY_EN, these ports and their logic SHALL be absent.

Structure
REQ-027 Opcode constants (LOAD 7'b0000011, STORE 7'b0100011, BRANCH, JAL, JALR) SHALL live in a shared package rv_defs, alongside the ROB entry struct typedef.
REQ-028 The pointer/count logic SHALL be one sub-module, rob_ptr_ctrl; entry storage and commit logic SHALL stay in reorder_buffer.

Verification
REQ-029 Reset mid-traffic (count=5): drive rst_in low asynchronously -> count=0, empty=1, commit_valid=0 before the next edge.
REQ-030 Issue 16 entries with no writeback -> issue_ready_out=0 at count 16; tags run 0..15, then wrap to 0 after one commit.
REQ-031 Writeback tags 2,1,0 in that order with values 0x22,0x11,0x00 -> commits tag order 0,1,2, one per cycle, values matching.
REQ-032 Issue at count 16 with the head done -> the issue is rejected that cycle; count stays 16 (15 after commit, plus 1 issued the next cycle).
REQ-033 Head branch writeback with mispredict=1, target 0x1000, plus same-cycle issue -> flush_out pulses once with flush_pc_out=0x1000; count=0 and the issue is dropped.
REQ-034 With rdy_in=0 for 3 cycles, hold issue/wb inputs -> no state change; the operation completes on the cycle rdy_in returns to 1.
